// File: rtl/mp64_memsys_pkg.sv
// Shared encodings, defaults and lane helpers for the mp64 memory responder.
package mp64_memsys_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;

  localparam logic [63:0] BRAM_BASE_DEFAULT   = 64'h0;
  localparam int unsigned BRAM_BYTES_DEFAULT  = 65536;
  localparam int unsigned EXT_TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {StIdle, StResp, StExtWait, StRecover} state_e;

  // Byte offset inside the 64-bit word with sub-size address bits cleared.
  function automatic logic [2:0] lane_offset(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] align;
    case (size)
      SIZE_BYTE: align = 3'b000;
      SIZE_HALF: align = 3'b001;
      SIZE_WORD: align = 3'b011;
      default:   align = 3'b111;
    endcase
    return addr_lo & ~align;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0f;
      default:   base = 8'hff;
    endcase
    return base << off;
  endfunction

  function automatic logic [63:0] size_data_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 64'h0000_0000_0000_00ff;
      SIZE_HALF: return 64'h0000_0000_0000_ffff;
      SIZE_WORD: return 64'h0000_0000_ffff_ffff;
      default:   return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/mp64_memsys_bram64.sv
// Single-port synchronous 64-bit RAM, 8 byte write enables, read-before-write.
module mp64_memsys_bram64 #(
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = 13
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [7:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  // No reset on the array or read register so block RAM can be inferred.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      for (int b = 0; b < 8; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mp64_memsys.sv
// Memory-port responder: internal byte-enabled BRAM or external port with timeout.
module mp64_memsys
  import mp64_memsys_pkg::*;
#(
  parameter logic [63:0] BRAM_BASE   = BRAM_BASE_DEFAULT,
  parameter int unsigned BRAM_BYTES  = BRAM_BYTES_DEFAULT,
  parameter int unsigned EXT_TIMEOUT = EXT_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mem_req,
  input  logic [63:0] i_mem_addr,
  input  logic [63:0] i_mem_wdata,
  input  logic        i_mem_wen,
  input  logic [1:0]  i_mem_size,
  output logic [63:0] o_mem_rdata,
  output logic        o_mem_ack,
  output logic        o_ext_req,
  output logic [63:0] o_ext_addr,
  output logic [63:0] o_ext_wdata,
  output logic        o_ext_wen,
  output logic [1:0]  o_ext_size,
  input  logic [63:0] i_ext_rdata,
  input  logic        i_ext_ack,
  output logic        o_bus_err
);

  localparam int unsigned WORDS = BRAM_BYTES / 8;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e      r_state, w_state_d;
  logic [2:0]  r_off;
  logic [1:0]  r_size;
  logic        r_from_ext, r_err;
  logic [63:0] r_ext_data, r_rdata;
  logic [15:0] r_cnt;
  logic        r_ext_req, r_ext_wen;
  logic [63:0] r_ext_addr, r_ext_wdata;
  logic [1:0]  r_ext_size;

  logic [63:0]      w_rel, w_bram_rdata, w_bram_wdata, w_resp_data;
  logic             w_in_bram, w_accept, w_bram_en, w_unused;
  logic [2:0]       w_off;
  logic [7:0]       w_bram_we;
  logic [IDX_W-1:0] w_idx;

  assign w_rel     = i_mem_addr - BRAM_BASE;
  assign w_in_bram = w_rel < 64'(BRAM_BYTES);
  assign w_idx     = w_rel[IDX_W+2:3];
  assign w_off     = lane_offset(i_mem_addr[2:0], i_mem_size);
  assign w_unused  = ^{w_rel[63:IDX_W+3], w_rel[2:0]};

  // rst_n gates the enable so a held request cannot write while reset is asserted.
  assign w_accept     = (r_state == StIdle) && i_mem_req && rst_n;
  assign w_bram_en    = w_accept && w_in_bram;
  assign w_bram_we    = (w_bram_en && i_mem_wen) ? lane_mask(i_mem_size, w_off) : 8'h00;
  assign w_bram_wdata = i_mem_wdata << {w_off, 3'b000};

  mp64_memsys_bram64 #(
    .DEPTH (WORDS),
    .AW    (IDX_W)
  ) u_bram (
    .clk     (clk),
    .i_en    (w_bram_en),
    .i_we    (w_bram_we),
    .i_addr  (w_idx),
    .i_wdata (w_bram_wdata),
    .o_rdata (w_bram_rdata)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (i_mem_req) w_state_d = w_in_bram ? StResp : StExtWait;
      StExtWait: if (i_ext_ack || r_cnt == 16'd1) w_state_d = StResp;
      StResp:    w_state_d = StRecover;
      StRecover: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_resp_data = r_ext_data;
    if (!r_from_ext) begin
      w_resp_data = (w_bram_rdata >> {r_off, 3'b000}) & size_data_mask(r_size);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off       <= '0;
      r_size      <= '0;
      r_from_ext  <= 1'b0;
      r_err       <= 1'b0;
      r_ext_data  <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_ext_req   <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_ext_wen   <= 1'b0;
      r_ext_size  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_mem_req) begin
            r_off      <= w_off;
            r_size     <= i_mem_size;
            r_err      <= 1'b0;
            r_from_ext <= !w_in_bram;
            if (!w_in_bram) begin
              r_ext_req   <= 1'b1;
              r_ext_addr  <= i_mem_addr;
              r_ext_wdata <= i_mem_wdata;
              r_ext_wen   <= i_mem_wen;
              r_ext_size  <= i_mem_size;
              r_cnt       <= 16'(EXT_TIMEOUT);
            end
          end
        end
        StExtWait: begin
          // An ack in the expiry cycle wins over the timeout.
          if (i_ext_ack) begin
            r_ext_req  <= 1'b0;
            r_ext_data <= i_ext_rdata;
          end else if (r_cnt == 16'd1) begin
            r_ext_req  <= 1'b0;
            r_ext_data <= '1;
            r_err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StResp:  r_rdata <= w_resp_data;
        default: ;
      endcase
    end
  end

  assign o_mem_ack   = (r_state == StResp);
  assign o_bus_err   = o_mem_ack && r_err;
  assign o_mem_rdata = o_mem_ack ? w_resp_data : r_rdata;
  assign o_ext_req   = r_ext_req;
  assign o_ext_addr  = r_ext_addr;
  assign o_ext_wdata = r_ext_wdata;
  assign o_ext_wen   = r_ext_wen;
  assign o_ext_size  = r_ext_size;

endmodule

// File: tb/tb_mp64_memsys.sv
// Self-checking bench for mp64_memsys: vector table, hand sequences, random vs byte model.
module tb_mp64_memsys;

  localparam int unsigned TB_BYTES   = 4096;
  localparam int unsigned TB_TIMEOUT = 8;

  logic        clk, rst_n;
  logic        i_mem_req, i_mem_wen, i_ext_ack;
  logic [63:0] i_mem_addr, i_mem_wdata, i_ext_rdata;
  logic [1:0]  i_mem_size;
  logic [63:0] o_mem_rdata, o_ext_addr, o_ext_wdata;
  logic        o_mem_ack, o_ext_req, o_ext_wen, o_bus_err;
  logic [1:0]  o_ext_size;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem_m [TB_BYTES];

  mp64_memsys #(
    .BRAM_BASE   (64'h0),
    .BRAM_BYTES  (TB_BYTES),
    .EXT_TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_req   (i_mem_req),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .i_mem_wen   (i_mem_wen),
    .i_mem_size  (i_mem_size),
    .o_mem_rdata (o_mem_rdata),
    .o_mem_ack   (o_mem_ack),
    .o_ext_req   (o_ext_req),
    .o_ext_addr  (o_ext_addr),
    .o_ext_wdata (o_ext_wdata),
    .o_ext_wen   (o_ext_wen),
    .o_ext_size  (o_ext_size),
    .i_ext_rdata (i_ext_rdata),
    .i_ext_ack   (i_ext_ack),
    .o_bus_err   (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic [1:0] size);
    int nb = 1 << size;
    int base = int'(addr[11:0]) & ~(nb - 1);
    logic [63:0] r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = mem_m[base + i];
    return r;
  endfunction

  task automatic model_write(input logic [63:0] addr, input logic [1:0] size,
                             input logic [63:0] wdata);
    int nb = 1 << size;
    int base = int'(addr[11:0]) & ~(nb - 1);
    for (int i = 0; i < nb; i++) mem_m[base + i] = wdata[8*i +: 8];
  endtask

  // One full transaction; mem_req stays high through RECOVER to exercise the ignore window.
  task automatic access(input logic [63:0] addr, input logic [63:0] wdata, input logic wen,
                        input logic [1:0] size, input int ext_delay, input logic [63:0] ext_rd,
                        output logic [63:0] rdata, output logic err, output int lat,
                        output int ext_cyc);
    bit done = 0;
    rdata = '0; err = 1'b0; lat = 0; ext_cyc = 0;
    @(negedge clk);
    i_mem_req = 1'b1; i_mem_addr = addr; i_mem_wdata = wdata;
    i_mem_wen = wen; i_mem_size = size;
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk);
      if (o_mem_ack) begin
        done = 1; lat = n; rdata = o_mem_rdata; err = o_bus_err; i_ext_ack = 1'b0;
      end else if (o_ext_req) begin
        ext_cyc++;
        if (ext_cyc == 1) begin
          chk("ext_addr", o_ext_addr, addr);
          chk("ext_fields", {o_ext_wen, o_ext_size}, {wen, size});
          if (wen) chk("ext_wdata", o_ext_wdata, wdata);
        end
        i_ext_ack   = (ext_delay != 0) && (ext_cyc == ext_delay);
        i_ext_rdata = i_ext_ack ? ext_rd : ~ext_rd;
      end else begin
        i_ext_ack = 1'b0;
      end
    end
    if (!done) chk("ack_wait_expired", 64'd0, 64'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ack_single_pulse", {o_mem_ack, o_ext_req}, 2'b00);
    end
    i_mem_req = 1'b0; i_mem_wen = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wen;
    logic [1:0]  size;
    logic        check;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [63:0] rd, ext_rd, exp_rd, wd, addr;
    logic        err, wen;
    logic [1:0]  size;
    int          lat, ecyc, delay;
    bit          is_ext;

    rst_n = 1'b0; i_mem_req = 1'b0; i_mem_addr = '0; i_mem_wdata = '0; i_mem_wen = 1'b0;
    i_mem_size = '0; i_ext_rdata = '0; i_ext_ack = 1'b0;
    for (int i = 0; i < int'(TB_BYTES); i++) mem_m[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk("reset_ack_req_err", {o_mem_ack, o_ext_req, o_bus_err, o_ext_wen}, 4'b0000);
    chk("reset_rdata", o_mem_rdata, 64'd0);
    chk("reset_ext_addr", o_ext_addr, 64'd0);
    rst_n = 1'b1;

    // Prefill the first 512 bytes so every later read has a known model value.
    for (int w = 0; w < 64; w++) begin
      wd = {$urandom, $urandom};
      access(64'(w * 8), wd, 1'b1, 2'd3, 0, 64'd0, rd, err, lat, ecyc);
      model_write(64'(w * 8), 2'd3, wd);
    end

    vecs[0]  = '{64'h10, 64'h1122334455667788, 1'b1, 2'd3, 1'b0, 64'h0};
    vecs[1]  = '{64'h10, 64'h0, 1'b0, 2'd3, 1'b1, 64'h1122334455667788};
    vecs[2]  = '{64'h13, 64'hAB, 1'b1, 2'd0, 1'b1, 64'h55};
    vecs[3]  = '{64'h10, 64'h0, 1'b0, 2'd3, 1'b1, 64'h11223344AB667788};
    vecs[4]  = '{64'h13, 64'h0, 1'b0, 2'd0, 1'b1, 64'hAB};
    vecs[5]  = '{64'h15, 64'hBEEF, 1'b1, 2'd1, 1'b1, 64'h3344};
    vecs[6]  = '{64'h10, 64'h0, 1'b0, 2'd3, 1'b1, 64'h1122BEEFAB667788};
    vecs[7]  = '{64'h15, 64'h0, 1'b0, 2'd1, 1'b1, 64'hBEEF};
    vecs[8]  = '{64'h16, 64'h0, 1'b0, 2'd2, 1'b1, 64'h1122BEEF};
    vecs[9]  = '{64'h18, 64'h0123456789ABCDEF, 1'b1, 2'd3, 1'b0, 64'h0};
    vecs[10] = '{64'h1F, 64'hCAFEF00D, 1'b1, 2'd2, 1'b1, 64'h01234567};
    vecs[11] = '{64'h18, 64'h0, 1'b0, 2'd3, 1'b1, 64'hCAFEF00D89ABCDEF};
    vecs[12] = '{64'h1A, 64'h0, 1'b0, 2'd0, 1'b1, 64'hAB};
    vecs[13] = '{64'h11, 64'hFFFFFFFFFFFFFF5A, 1'b1, 2'd0, 1'b1, 64'h77};
    vecs[14] = '{64'h10, 64'h0, 1'b0, 2'd3, 1'b1, 64'h1122BEEFAB665A88};

    foreach (vecs[i]) begin
      access(vecs[i].addr, vecs[i].wdata, vecs[i].wen, vecs[i].size, 0, 64'd0, rd, err, lat, ecyc);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
      chk($sformatf("vec%0d_err_ext", i), {63'(ecyc), err}, 64'd0);
      if (vecs[i].check) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      if (vecs[i].wen) model_write(vecs[i].addr, vecs[i].size, vecs[i].wdata);
    end

    // mem_rdata holds between acks.
    repeat (3) @(negedge clk);
    chk("rdata_hold", o_mem_rdata, 64'h1122BEEFAB665A88);

    access(64'h2000_0000, 64'd0, 1'b0, 2'd3, 5, 64'hDEADBEEF, rd, err, lat, ecyc);
    chk("ext5_req_cycles", 64'(ecyc), 64'd5);
    chk("ext5_latency", 64'(lat), 64'd6);
    chk("ext5_rdata", rd, 64'hDEADBEEF);
    chk("ext5_bus_err", 64'(err), 64'd0);

    access(64'h2000_0100, 64'd0, 1'b0, 2'd2, 0, 64'd0, rd, err, lat, ecyc);
    chk("tmo_req_cycles", 64'(ecyc), 64'(TB_TIMEOUT));
    chk("tmo_latency", 64'(lat), 64'(TB_TIMEOUT + 1));
    chk("tmo_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("tmo_bus_err", 64'(err), 64'd1);
    access(64'h10, 64'd0, 1'b0, 2'd3, 0, 64'd0, rd, err, lat, ecyc);
    chk("after_tmo_latency", 64'(lat), 64'd1);
    chk("after_tmo_rdata", rd, model_read(64'h10, 2'd3));
    chk("after_tmo_err", 64'(err), 64'd0);

    access(64'h2000_0200, 64'd0, 1'b0, 2'd3, TB_TIMEOUT, 64'h0BAD_F00D_1234_5678, rd, err, lat, ecyc);
    chk("ack_at_expiry_rdata", rd, 64'h0BAD_F00D_1234_5678);
    chk("ack_at_expiry_err", 64'(err), 64'd0);

    access(64'h3000_0009, 64'h55AA, 1'b1, 2'd1, 2, 64'd0, rd, err, lat, ecyc);
    chk("ext_write_cycles", 64'(ecyc), 64'd2);

    // Range boundary: last BRAM byte is internal, the next address is external.
    access(64'(TB_BYTES - 1), 64'h77, 1'b1, 2'd0, 0, 64'd0, rd, err, lat, ecyc);
    chk("top_byte_internal", {32'(lat), 32'(ecyc)}, {32'd1, 32'd0});
    access(64'(TB_BYTES - 1), 64'd0, 1'b0, 2'd0, 0, 64'd0, rd, err, lat, ecyc);
    chk("top_byte_read", rd, 64'h77);
    access(64'(TB_BYTES), 64'd0, 1'b0, 2'd3, 1, 64'h1357, rd, err, lat, ecyc);
    chk("past_top_external", {32'(ecyc), rd[31:0]}, {32'd1, 32'h1357});

    // Reset during EXT_WAIT, with a write request held while reset is low.
    @(negedge clk);
    i_mem_req = 1'b1; i_mem_addr = 64'h4000_0000; i_mem_wen = 1'b0; i_mem_size = 2'd3;
    for (int n = 0; n < 20 && !o_ext_req; n++) @(negedge clk);
    chk("ext_req_before_reset", 64'(o_ext_req), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {o_ext_req, o_mem_ack, o_bus_err}, 3'b000);
    i_mem_addr = 64'h20; i_mem_wen = 1'b1; i_mem_wdata = ~model_read(64'h20, 2'd3);
    repeat (3) @(negedge clk);
    i_mem_req = 1'b0; i_mem_wen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(64'h20, 64'd0, 1'b0, 2'd3, 0, 64'd0, rd, err, lat, ecyc);
    chk("post_reset_latency", 64'(lat), 64'd1);
    chk("no_write_in_reset", rd, model_read(64'h20, 2'd3));

    // Random mix against the byte-array model.
    for (int t = 0; t < 250; t++) begin
      is_ext = ($urandom_range(0, 9) < 2);
      size   = 2'($urandom_range(0, 3));
      wen    = 1'($urandom_range(0, 1));
      wd     = {$urandom, $urandom};
      if (is_ext) begin
        addr   = 64'h8000_0000 + 64'($urandom_range(0, 65535));
        delay  = int'($urandom_range(0, 10));
        ext_rd = {$urandom, $urandom};
        access(addr, wd, wen, size, delay, ext_rd, rd, err, lat, ecyc);
        if (delay >= 1 && delay <= int'(TB_TIMEOUT)) begin
          chk("rnd_ext_rdata", rd, ext_rd);
          chk("rnd_ext_err_lat", {63'(lat), err}, {63'(delay + 1), 1'b0});
        end else begin
          chk("rnd_tmo_rdata", rd, 64'hFFFF_FFFF_FFFF_FFFF);
          chk("rnd_tmo_err_lat", {63'(lat), err}, {63'(TB_TIMEOUT + 1), 1'b1});
        end
      end else begin
        addr   = 64'($urandom_range(0, 511));
        exp_rd = model_read(addr, size);
        access(addr, wd, wen, size, 0, 64'd0, rd, err, lat, ecyc);
        chk("rnd_bram_rdata", rd, exp_rd);
        chk("rnd_bram_lat", {62'(lat), err, 1'(ecyc != 0)}, {62'd1, 1'b0, 1'b0});
        if (wen) model_write(addr, size, wd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mp64_memsys.md
Name: mp64_memsys

Overview:
Responder end of the arbiter's memory port. It accepts one request at a time on the mem_* interface and services it from an internal byte-enabled BRAM, or forwards it to an external memory port with a timeout. It returns mem_rdata with a single-cycle mem_ack pulse. It sits between the bus arbiter and the external memory controller.

Parameters:
BRAM_BASE, 64'h0, byte base address of internal BRAM (aligned to BRAM_BYTES)
BRAM_BYTES, 65536, internal BRAM size in bytes (power of two, multiple of 8)
EXT_TIMEOUT, 1023, max cycles to wait for ext_ack before error completion (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  request valid; held by master until ack is seen
mem_addr  in  64  byte address
mem_wdata  in  64  write data, right-justified
mem_wen  in  1  1=write, 0=read
mem_size  in  2  0=byte, 1=half, 2=word32, 3=dword64
mem_rdata  out  64  read data, right-justified, zero-extended
mem_ack  out  1  one-cycle completion pulse
ext_req  out  1  external request, held until ext_ack or timeout
ext_addr  out  64  external byte address
ext_wdata  out  64  external write data
ext_wen  out  1  external write enable
ext_size  out  2  external size
ext_rdata  in  64  external read data, valid with ext_ack
ext_ack  in  1  external completion
bus_err  out  1  one-cycle pulse coincident with mem_ack on a timed-out access

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. The reset state is IDLE. All outputs reset to 0.
- A reset asserted mid-access drops ext_req immediately and abandons the access. No BRAM write occurs after reset assertion.
- States: IDLE, RESP, EXT_WAIT, RECOVER.
- IDLE, mem_req=1, address inside [BRAM_BASE, BRAM_BASE+BRAM_BYTES): latch addr[2:0], size and wen; go to RESP.
  - Writes commit to BRAM at this clock edge with byte enables.
  - Reads issue a synchronous BRAM read.
- IDLE, mem_req=1, address outside the BRAM range: register ext_* from mem_* and assert ext_req the next cycle. Load the timeout counter with EXT_TIMEOUT. Go to EXT_WAIT.
- EXT_WAIT:
  - ext_ack=1: capture ext_rdata, drop ext_req, go to RESP.
  - Otherwise decrement the counter. On reaching 0, drop ext_req, set rdata to all-ones, flag an error, go to RESP.
  - An ext_ack arriving in the same cycle as counter expiry counts as success.
- RESP: mem_ack=1 for exactly one cycle. bus_err=1 only if the access timed out. Go to RECOVER.
- RECOVER: mem_req is ignored for this one cycle, because the master's registered request is still high while it observes the ack. Go to IDLE.
- Back-to-back latency:
  - BRAM access: ack one cycle after acceptance; next acceptance possible two cycles after the ack.
  - External access: ack one cycle after ext_ack.
- Alignment: address bits below the size alignment are ignored (forced aligned), so an access never crosses a 64-bit word.
- Lane rules, little-endian, offset = addr[2:0] & ~(size mask):
  - byte enable = size-wide mask shifted by offset.
  - BRAM write data = wdata shifted left by 8*offset.
  - read data = BRAM word shifted right by 8*offset, masked to the size, and zero-extended.
- External read data is passed through unmodified; the external side performs its own lane handling.
- The BRAM word index is (addr - BRAM_BASE)[log2(BRAM_BYTES)-1:3].
- mem_rdata holds its last value between acks and is don't-care for writes. Write acks return the BRAM value before the write.

Decomposition:
- mp64_defs.vh gains the SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_DWORD encodings, BRAM_BASE, BRAM_BYTES and EXT_TIMEOUT defaults, and the byte-lane mask function.
- Sub-module mp64_bram64: a single-port synchronous 64-bit RAM with 8 byte-write-enables and read-before-write behaviour. It is the inference target for FPGA block RAM.

Test Plan:
- Write dword 0x1122334455667788 to 0x10, then read dword 0x10 -> mem_ack one cycle after each acceptance; read returns 0x1122334455667788; exactly one write occurs even though mem_req stays high through RECOVER.
- Write byte 0xAB to 0x13, then read dword 0x10 -> returns 0x11223344AB667788; read byte 0x13 returns 0x00000000000000AB.
- Write half 0xBEEF to 0x15 (misaligned) -> forced to 0x14; dword read returns 0x1122BEEFAB667788.
- Read 0x2000_0000 with ext_ack after 5 cycles carrying 0xDEADBEEF -> ext_req high 5 cycles, ext_addr=0x2000_0000, mem_rdata=0xDEADBEEF, bus_err=0.
- External read with ext_ack never asserted, EXT_TIMEOUT=8 -> ext_req drops after 8 cycles; mem_ack with mem_rdata=all-ones and bus_err=1; next request accepted normally.
- Assert rst_n low during EXT_WAIT -> ext_req, mem_ack and bus_err go to 0 asynchronously; after release, a BRAM read completes in the normal number of cycles.
